i3c_cmd_ctrl: RTL and testbench

Command sequencer behind the I3C_BUS serial slave, running on the system clock. It takes each 16-bit word received by I3C_BUS (parallel_dout/data_ready), decodes it as a command, updates a bank of 8-bit configuration registers or runs a request/acknowledge with a capture engine, then loads a 16-bit response word for I3C_BUS to shift out on the next frame (parallel_din).

---
 rtl/i3c_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_i3c_cmd_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i3c_cmd_ctrl.sv
// i3c_cmd_ctrl: decodes 16-bit words from the I3C_BUS slave, updates an 8-bit register bank or
// runs a go_req/go_ack exchange, then loads a response word. Define CTRL_WDOG_EN for the go_ack watchdog.
module i3c_cmd_ctrl #(
  parameter int NREG        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       rx_word,
  input  logic              rx_ready,
  output logic [15:0]       resp_word,
  output logic              resp_valid,
  output logic [8*NREG-1:0] cfg_bus,
  output logic              go_req,
  input  logic              go_ack,
  output logic              busy,
  output logic              err_flag,
  output logic [2:0]        dbg_state_o
);

  // Handshakes: a new command is the rising edge of synchronized rx_ready (rx_word held stable
  // while rx_ready is high); go_req is held high until go_ack is sampled, go_ack is ignored otherwise.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_prev_q;
  logic                   cmd_event;

  logic [2:0]  state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [7:0]  regs_q [NREG];
  logic [7:0]  regs_d [NREG];
  logic [15:0] resp_word_q, resp_word_d;
  logic        resp_valid_q, resp_valid_d;
  logic        go_req_q, go_req_d;
  logic        err_ill_q, err_ill_d;
  logic        err_ovr_q, err_ovr_d;
  logic        err_wdog_q, err_wdog_d;
  logic        err_flag_q;
  logic [7:0]  cmd_cnt_q, cmd_cnt_d;

  logic [3:0]  cmd_op, cmd_addr;
  logic [7:0]  cmd_data, rd_val, wr_val;
  logic        addr_ok, cmd_legal, wr_en;
  logic        set_ill, set_ovr, set_wdog, clr_err;

`ifdef CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      rdy_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_ready};
      rdy_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cmd_event = sync_q[SYNC_STAGES-1] & ~rdy_prev_q;

  assign cmd_op   = cmd_q[15:12];
  assign cmd_addr = cmd_q[11:8];
  assign cmd_data = cmd_q[7:0];
  assign addr_ok  = ({1'b0, cmd_addr} < 5'(NREG));

  always_comb begin
    case (cmd_op)
      4'h0, 4'h5, 4'hF:       cmd_legal = 1'b1;
      4'h1, 4'h2, 4'h3, 4'h4: cmd_legal = addr_ok;
      default:                cmd_legal = 1'b0;
    endcase
  end

  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (cmd_addr == 4'(k)) rd_val = regs_q[k];
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    resp_word_d  = resp_word_q;
    resp_valid_d = 1'b0;
    go_req_d     = go_req_q;
    cmd_cnt_d    = cmd_cnt_q;
    wr_en        = 1'b0;
    wr_val       = 8'h00;
    set_ill      = 1'b0;
    set_wdog     = 1'b0;
    clr_err      = 1'b0;
    set_ovr      = cmd_event && (state_q != S_IDLE);
`ifdef CTRL_WDOG_EN
    wdog_cnt_d   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_event) begin
          cmd_d   = rx_word;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cmd_legal) begin
          set_ill      = 1'b1;
          resp_word_d  = {4'hE, cmd_op, 8'h00};
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
        case (cmd_op)
          4'h0: resp_word_d = 16'h0000;
          4'h1: begin
            wr_en  = 1'b1;
            wr_val = cmd_data;
          end
          4'h2: resp_word_d = {4'h2, cmd_addr, rd_val};
          4'h3: begin
            wr_en  = 1'b1;
            wr_val = rd_val | cmd_data;
          end
          4'h4: begin
            wr_en  = 1'b1;
            wr_val = rd_val & ~cmd_data;
          end
          4'h5: begin
            go_req_d     = 1'b1;
            resp_valid_d = 1'b0;
            state_d      = S_WAIT_ACK;
          end
          4'hF: begin
            resp_word_d = {4'hF, err_ill_q, err_ovr_q, err_wdog_q, 1'b0, cmd_cnt_q};
            clr_err     = 1'b1;
          end
          default: begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        endcase
        if (wr_en) resp_word_d = {cmd_op, cmd_addr, wr_val};
      end
      S_WAIT_ACK: begin
        if (go_ack) begin
          go_req_d     = 1'b0;
          resp_word_d  = {4'h5, 12'h001};
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
`ifdef CTRL_WDOG_EN
        // The ack check above takes priority, so an ack in the timeout cycle wins.
        else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          go_req_d     = 1'b0;
          set_wdog     = 1'b1;
          resp_word_d  = {4'h5, 12'hFFF};
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        cmd_cnt_d = cmd_cnt_q + 8'd1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int k = 0; k < NREG; k++) begin
      regs_d[k] = (wr_en && (cmd_addr == 4'(k))) ? wr_val : regs_q[k];
    end

    // A clear from STAT loses against an error raised in the same cycle.
    err_ill_d  = (err_ill_q  & ~clr_err) | set_ill;
    err_ovr_d  = (err_ovr_q  & ~clr_err) | set_ovr;
    err_wdog_d = (err_wdog_q & ~clr_err) | set_wdog;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= 16'h0000;
      resp_word_q  <= 16'h0000;
      resp_valid_q <= 1'b0;
      go_req_q     <= 1'b0;
      err_ill_q    <= 1'b0;
      err_ovr_q    <= 1'b0;
      err_wdog_q   <= 1'b0;
      err_flag_q   <= 1'b0;
      cmd_cnt_q    <= 8'h00;
      for (int k = 0; k < NREG; k++) regs_q[k] <= 8'h00;
`ifdef CTRL_WDOG_EN
      wdog_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      resp_word_q  <= resp_word_d;
      resp_valid_q <= resp_valid_d;
      go_req_q     <= go_req_d;
      err_ill_q    <= err_ill_d;
      err_ovr_q    <= err_ovr_d;
      err_wdog_q   <= err_wdog_d;
      err_flag_q   <= err_ill_d | err_ovr_d | err_wdog_d;
      cmd_cnt_q    <= cmd_cnt_d;
      for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
`ifdef CTRL_WDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < NREG; k++) cfg_bus[8*k +: 8] = regs_q[k];
  end

  assign resp_word   = resp_word_q;
  assign resp_valid  = resp_valid_q;
  assign go_req      = go_req_q;
  assign busy        = (state_q != S_IDLE);
  assign err_flag    = err_flag_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i3c_cmd_ctrl.sv
// Bench for i3c_cmd_ctrl: transaction-scheduling reference model compared every cycle,
// directed literal checks from the command table, then randomized command traffic.
module tb_i3c_cmd_ctrl;
  localparam int NREG = 8;
  localparam int SYNC = 2;
  localparam int WDOG = 16;
`ifdef CTRL_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] rx_word;
  logic rx_ready;
  logic [15:0] resp_word;
  logic resp_valid;
  logic [8*NREG-1:0] cfg_bus;
  logic go_req;
  logic go_ack;
  logic busy;
  logic err_flag;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;
  bit auto_ack = 1'b0;
  int manual_ack = 0;
  int ack_done = 0;

  i3c_cmd_ctrl #(.NREG(NREG), .SYNC_STAGES(SYNC), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .rx_word(rx_word), .rx_ready(rx_ready),
    .resp_word(resp_word), .resp_valid(resp_valid), .cfg_bus(cfg_bus),
    .go_req(go_req), .go_ack(go_ack), .busy(busy), .err_flag(err_flag),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
    end
  endfunction

  function automatic void bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endfunction

  // ---------------- reference model ----------------
  bit          m_sh [SYNC];
  bit          m_prev;
  logic [7:0]  m_reg [16];
  logic [15:0] m_resp, m_cmd;
  bit          m_valid, m_goreq, m_busy, m_ill, m_ovr, m_wdog, m_wait;
  logic [7:0]  m_cnt;
  int          m_edge, m_exec, m_fin, m_wait_n;

  function automatic bit is_legal(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    if (op == 4'h0 || op == 4'h5 || op == 4'hF) return 1'b1;
    if (op >= 4'h1 && op <= 4'h4) return (int'(w[11:8]) < NREG);
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_cfg();
    logic [63:0] c;
    c = '0;
    for (int k = 0; k < NREG; k++) c[8*k +: 8] = m_reg[k];
    return c;
  endfunction

  function automatic void m_respond(input logic [15:0] w);
    m_resp  = w;
    m_valid = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    m_prev = 0; m_resp = 16'h0; m_cmd = 16'h0; m_valid = 0; m_goreq = 0; m_busy = 0;
    m_ill = 0; m_ovr = 0; m_wdog = 0; m_wait = 0; m_cnt = 8'h0;
    m_edge = 0; m_exec = -1; m_fin = -1; m_wait_n = 0;
  endfunction

  function automatic void model_step();
    bit ev, was_busy;
    logic [3:0] op, a;
    logic [7:0] d;
    m_edge++;
    ev = m_sh[SYNC-1] && !m_prev;
    m_prev = m_sh[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = rx_ready;
    was_busy = m_busy;
    m_valid = 1'b0;
    if (m_wait) begin
      if (go_ack) begin
        m_wait = 0; m_goreq = 0; m_respond(16'h5001); m_fin = m_edge + 1;
      end else if (WDOG_ON) begin
        m_wait_n++;
        if (m_wait_n == WDOG) begin
          m_wait = 0; m_goreq = 0; m_wdog = 1; m_respond(16'h5FFF); m_fin = m_edge + 1;
        end
      end
    end
    if (m_busy && m_edge == m_exec) begin
      op = m_cmd[15:12]; a = m_cmd[11:8]; d = m_cmd[7:0];
      if (!is_legal(m_cmd)) begin
        m_ill = 1;
        m_respond({4'hE, op, 8'h00});
      end else begin
        case (op)
          4'h0: m_respond(16'h0000);
          4'h1: begin m_reg[a] = d; m_respond({op, a, m_reg[a]}); end
          4'h2: m_respond({op, a, m_reg[a]});
          4'h3: begin m_reg[a] = m_reg[a] | d; m_respond({op, a, m_reg[a]}); end
          4'h4: begin m_reg[a] = m_reg[a] & ~d; m_respond({op, a, m_reg[a]}); end
          4'h5: begin m_goreq = 1; m_wait = 1; m_wait_n = 0; end
          default: begin
            m_respond({4'hF, m_ill, m_ovr, m_wdog, 1'b0, m_cnt});
            m_ill = 0; m_ovr = 0; m_wdog = 0;
          end
        endcase
      end
    end
    if (m_busy && m_edge == m_fin) begin
      m_busy = 0;
      m_cnt = m_cnt + 8'd1;
    end
    if (ev) begin
      if (was_busy) m_ovr = 1;
      else begin
        m_cmd = rx_word;
        m_busy = 1;
        if (!is_legal(rx_word)) begin
          m_exec = m_edge + 1; m_fin = m_edge + 2;
        end else begin
          m_exec = m_edge + 2;
          m_fin = (rx_word[15:12] == 4'h5) ? -1 : m_edge + 3;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("resp_word", resp_word, m_resp);
      chk("resp_valid", resp_valid, m_valid);
      chk("cfg_bus", cfg_bus, m_cfg());
      chk("go_req", go_req, m_goreq);
      chk("busy", busy, m_busy);
      chk("err_flag", err_flag, m_ill | m_ovr | m_wdog);
    end
  end

  // ---------------- drivers ----------------
  initial begin
    go_ack = 1'b0;
    forever begin
      @(negedge clk);
      go_ack = 1'b0;
      if (manual_ack != ack_done) begin
        go_ack = 1'b1;
        ack_done = manual_ack;
      end else if (auto_ack && rst_n === 1'b1) begin
        if (go_req) go_ack = ($urandom_range(0, 5) == 0);
        else go_ack = ($urandom_range(0, 40) == 0);
      end
    end
  end

  task automatic do_cmd(input logic [15:0] w, input int ack_at, output logic [15:0] r, output int lat);
    bit got;
    got = 0; lat = 0; r = 16'h0;
    @(negedge clk);
    rx_word = w;
    rx_ready = 1'b1;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 3) rx_ready = 1'b0;
      if (ack_at > 0 && lat == ack_at) manual_ack++;
      if (resp_valid) begin
        got = 1;
        r = resp_word;
      end
    end
    rx_ready = 1'b0;
    if (!got) bound_fail("do_cmd_response");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_go(input int limit);
    int n;
    n = 0;
    while (!go_req && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!go_req) bound_fail("wait_go_req");
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) bound_fail("wait_idle");
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [3:0] op;
    case ($urandom_range(0, 9))
      0: op = 4'h0;
      1: op = 4'h1;
      2: op = 4'h2;
      3: op = 4'h3;
      4: op = 4'h4;
      5: op = 4'h5;
      6: op = 4'hF;
      7: op = 4'($urandom_range(6, 14));
      default: op = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'h2;
    endcase
    return {op, 4'($urandom_range(0, 9)), 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    logic [15:0] r;
    int lat;
    rx_word = 16'h0;
    rx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_word", resp_word, 16'h0000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_cfg_bus", cfg_bus, 64'h0);
    chk("rst_go_req", go_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);

    do_cmd(16'h13A5, 0, r, lat);
    chk("wr_resp", r, 16'h13A5);
    chk("wr_latency", lat, SYNC + 3);
    chk("wr_cfg_reg3", cfg_bus[31:24], 8'hA5);

    do_cmd(16'h12F0, 0, r, lat);
    chk("wr2_resp", r, 16'h12F0);
    do_cmd(16'h320F, 0, r, lat);
    chk("setb_resp", r, 16'h32FF);
    do_cmd(16'h4281, 0, r, lat);
    chk("clrb_resp", r, 16'h427E);
    chk("clrb_reg2", cfg_bus[23:16], 8'h7E);

    do_cmd(16'h5000, 15, r, lat);
    chk("go_resp", r, 16'h5001);
    chk("go_busy_after", busy, 1'b0);

    // overrun: second word arrives while waiting for go_ack
    @(negedge clk);
    rx_word = 16'h5000; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    wait_go(20);
    repeat (3) @(negedge clk);
    rx_word = 16'h1155; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_err_flag", err_flag, 1'b1);
    manual_ack++;
    wait_idle(20);
    repeat (3) @(negedge clk);
    chk("ovr_dropped_reg1", cfg_bus[15:8], 8'h00);
    do_cmd(16'hF000, 0, r, lat);
    chk("stat_ovr", r, 16'hF406);
    do_cmd(16'hF000, 0, r, lat);
    chk("stat_cleared", r, 16'hF007);

    do_cmd(16'h7000, 0, r, lat);
    chk("ill_op_resp", r, 16'hE700);
    chk("ill_latency", lat, SYNC + 2);
    do_cmd(16'h1900, 0, r, lat);
    chk("ill_addr_resp", r, 16'hE100);
    chk("ill_err_flag", err_flag, 1'b1);
    chk("ill_cfg_unchanged", cfg_bus, 64'h00000000_A57E0000);
    do_cmd(16'hF000, 0, r, lat);
    chk("stat_ill", r, 16'hF80A);
    chk("stat_clears_flag", err_flag, 1'b0);

    auto_ack = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      rx_word = rand_cmd();
      rx_ready = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rx_ready = 1'b0;
      repeat ($urandom_range(2, 9)) @(negedge clk);
    end
    wait_idle(300);
    auto_ack = 1'b0;
    repeat (4) @(negedge clk);

    // reset in the middle of WAIT_ACK
    @(negedge clk);
    rx_word = 16'h5000; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    wait_go(20);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_go_req", go_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cfg", cfg_bus, 64'h0);
    chk("mid_rst_err", err_flag, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_cmd(16'h1012, 0, r, lat);
    chk("post_rst_wr", r, 16'h1012);

`ifdef CTRL_WDOG_EN
    begin
      int hi_cycles;
      int n;
      hi_cycles = 0; n = 0;
      @(negedge clk);
      rx_word = 16'h5000; rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      rx_ready = 1'b0;
      wait_go(20);
      while (go_req && n < 200) begin
        hi_cycles++;
        @(negedge clk);
        n++;
      end
      chk("wdog_go_cycles", hi_cycles, WDOG);
      chk("wdog_resp", resp_word, 16'h5FFF);
      chk("wdog_err_flag", err_flag, 1'b1);
      wait_idle(20);
    end
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
